// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: command encoding, default counter width and the
// master-index width helper used by the response arbiter and its grant logic.
package xbar_pkg;

    localparam logic CMD_READ    = 1'b0;
    localparam int   OUTST_W_DEF = 8;

    // Index width for n masters, never narrower than one bit.
    function automatic int master_log2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority grant: one-hot grant to the first requester after the last
// winner; the last winner starts at N-1 so index 0 wins first after reset.
module rr_grant
    import xbar_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N-1:0]              req_i,
    output logic [N-1:0]              grant_o,
    output logic [master_log2(N)-1:0] grant_idx_o
);

    localparam int IW = master_log2(N);

    logic [IW-1:0] last_q;
    logic [IW-1:0] idx;
    logic          hit;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        hit         = 1'b0;
        idx         = last_q;
        for (int off = 0; off < N; off++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
            if (!hit && req_i[idx]) begin
                hit            = 1'b1;
                grant_o[idx]   = 1'b1;
                grant_idx_o    = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= IW'(N - 1);
        end else if (hit) begin
            last_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/resp_arbiter_n.sv
// Read-response return path: tracks outstanding reads per channel, aligns and queues
// responses, and returns them one per cycle by round-robin. Error flags need RESP_ARB_ERR_EN.
module resp_arbiter_n
    import xbar_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int MASTER_NUM = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_DELAY = 2,
    parameter int OUTST_W    = OUTST_W_DEF
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                req,
    input  logic                                ack,
    input  logic                                cmd,
    input  logic [master_log2(MASTER_NUM)-1:0]  master_sel,
    input  logic [MASTER_NUM-1:0]               resp_in,
    input  logic [MASTER_NUM*DWIDTH-1:0]        rdata_in,
    output logic                                resp_out,
    output logic [DWIDTH-1:0]                   rdata_out
`ifdef RESP_ARB_ERR_EN
    ,
    output logic                                err_unsol,
    output logic                                err_ovf
`endif
);

    localparam int SW = master_log2(MASTER_NUM);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic                          rd_done_q;
    logic [SW-1:0]                 sel_q;
    logic [MASTER_NUM-1:0]         pv_q [RESP_DELAY];
    logic [MASTER_NUM*DWIDTH-1:0]  pd_q [RESP_DELAY];
    logic [MASTER_NUM-1:0]         push_v;
    logic [MASTER_NUM*DWIDTH-1:0]  push_d;
    logic [MASTER_NUM-1:0]         nonempty;
    logic [MASTER_NUM-1:0]         grant;
    logic [SW-1:0]                 grant_idx;
    logic [MASTER_NUM-1:0][DWIDTH-1:0] head;
    logic                          resp_q;
    logic [DWIDTH-1:0]             rdata_q;
`ifdef RESP_ARB_ERR_EN
    logic [MASTER_NUM-1:0]         unsol_ev;
    logic [MASTER_NUM-1:0]         ovf_ev;
    logic                          err_unsol_q;
    logic                          err_ovf_q;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_done_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            rd_done_q <= req & ack & (cmd == CMD_READ);
            sel_q     <= master_sel;
        end
    end

    // Alignment pipeline; the last stage is where responses are matched and pushed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int s = 0; s < RESP_DELAY; s++) begin
                pv_q[s] <= '0;
                pd_q[s] <= '0;
            end
        end else begin
            pv_q[0] <= resp_in;
            pd_q[0] <= rdata_in;
            for (int s = 1; s < RESP_DELAY; s++) begin
                pv_q[s] <= pv_q[s-1];
                pd_q[s] <= pd_q[s-1];
            end
        end
    end

    assign push_v = pv_q[RESP_DELAY-1];
    assign push_d = pd_q[RESP_DELAY-1];

    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_ch
        logic [OUTST_W-1:0] cnt_q;
        logic [OUTST_W-1:0] cnt_d;
        logic [PW:0]        wr_q;
        logic [PW:0]        rd_q;
        logic [DWIDTH-1:0]  mem [FIFO_DEPTH];
        logic               inc;
        logic               push;
        logic               full;
        logic               wr_en;

        assign inc   = rd_done_q && (sel_q == SW'(gi));
        assign push  = push_v[gi] && (cnt_q != '0);
        assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
        // A full FIFO still accepts a push when its head leaves in the same cycle.
        assign wr_en = push && (!full || grant[gi]);

        assign nonempty[gi] = (wr_q != rd_q);
        assign head[gi]     = mem[rd_q[PW-1:0]];

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !push && (cnt_q != '1)) begin
                cnt_d = cnt_q + OUTST_W'(1);
            end else if (push && !inc) begin
                cnt_d = cnt_q - OUTST_W'(1);
            end
        end

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                cnt_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (wr_en) begin
                    wr_q <= wr_q + (PW+1)'(1);
                end
                if (grant[gi]) begin
                    rd_q <= rd_q + (PW+1)'(1);
                end
            end
        end

        always_ff @(posedge aclk) begin
            if (wr_en) begin
                mem[wr_q[PW-1:0]] <= push_d[gi*DWIDTH +: DWIDTH];
            end
        end

`ifdef RESP_ARB_ERR_EN
        assign unsol_ev[gi] = push_v[gi] && (cnt_q == '0);
        assign ovf_ev[gi]   = (push && full && !grant[gi]) ||
                              (inc && !push && (cnt_q == '1));
`endif
    end

    rr_grant #(
        .N (MASTER_NUM)
    ) u_rr_grant (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .req_i       (nonempty),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= |nonempty;
            rdata_q <= (|nonempty) ? head[grant_idx] : '0;
        end
    end

    assign resp_out  = resp_q;
    assign rdata_out = rdata_q;

`ifdef RESP_ARB_ERR_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_unsol_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            err_unsol_q <= err_unsol_q | (|unsol_ev);
            err_ovf_q   <= err_ovf_q | (|ovf_ev);
        end
    end

    assign err_unsol = err_unsol_q;
    assign err_ovf   = err_ovf_q;
`endif

endmodule

// File: tb/tb_resp_arbiter_n.sv
// Directed bench for resp_arbiter_n at default parameters; error-flag checks are
// compiled in only when RESP_ARB_ERR_EN is defined.
module tb_resp_arbiter_n;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         req;
    logic         ack;
    logic         cmd;
    logic [1:0]   master_sel;
    logic [3:0]   resp_in;
    logic [127:0] rdata_in;
    logic         resp_out;
    logic [31:0]  rdata_out;
`ifdef RESP_ARB_ERR_EN
    logic         err_unsol;
    logic         err_ovf;
`endif

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int idle_bad = 0;
    logic [31:0] q_data[$];
    int          q_cyc[$];

    resp_arbiter_n dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req        (req),
        .ack        (ack),
        .cmd        (cmd),
        .master_sel (master_sel),
        .resp_in    (resp_in),
        .rdata_in   (rdata_in),
        .resp_out   (resp_out),
        .rdata_out  (rdata_out)
`ifdef RESP_ARB_ERR_EN
        ,
        .err_unsol  (err_unsol),
        .err_ovf    (err_ovf)
`endif
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record every returned pulse with the cycle it appeared in.
    always @(negedge aclk) begin
        if (resp_out === 1'b1) begin
            q_data.push_back(rdata_out);
            q_cyc.push_back(cyc);
        end else if (cyc > 0 && rdata_out !== 32'h0) begin
            idle_bad++;
        end
    end

    function automatic logic [31:0] mk(input int ch, input int k);
        return 32'hD000_0000 + 32'(ch * 256) + 32'(k);
    endfunction

    function automatic logic [127:0] pack_k(input int k);
        logic [127:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch*32 +: 32] = mk(ch, k);
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_inputs();
        req = 1'b0; ack = 1'b0; cmd = 1'b0; master_sel = 2'd0;
        resp_in = 4'b0; rdata_in = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        aresetn = 1'b1;
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic issue(input int ch, input logic rq, input logic ak, input logic cm);
        req = rq; ack = ak; cmd = cm; master_sel = 2'(ch);
        tick();
        req = 1'b0; ack = 1'b0; cmd = 1'b0;
    endtask

    task automatic drive_resp(input logic [3:0] mask, input logic [127:0] data);
        resp_in = mask; rdata_in = data;
        tick();
        resp_in = 4'b0; rdata_in = '0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        clear_inputs();
        req = 1'b1; ack = 1'b1; resp_in = 4'b1111; rdata_in = pack_k(9);
        tick();
        tick();
        n_checks++;
        if (resp_out !== 1'b0) begin n_err++; $display("FAIL reset_resp_out: got %b want 0", resp_out); end
        n_checks++;
        if (rdata_out !== 32'h0) begin n_err++; $display("FAIL reset_rdata_out: got %h want 0", rdata_out); end
`ifdef RESP_ARB_ERR_EN
        n_checks++;
        if (err_unsol !== 1'b0 || err_ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_err_flags: got unsol=%b ovf=%b want 0 0", err_unsol, err_ovf);
        end
`endif
        clear_inputs();
        aresetn = 1'b1;
        q_data.delete(); q_cyc.delete();
        idle(8);
        n_checks++;
        if (q_data.size() != 0) begin n_err++; $display("FAIL reset_no_pulses: got %0d pulses want 0", q_data.size()); end
        $display("test_reset: done");
    endtask

    task automatic test_single_read();
        int c;
        do_reset();
        issue(2, 1'b1, 1'b1, 1'b1);   // write: not outstanding
        issue(2, 1'b1, 1'b0, 1'b0);   // request not accepted
        issue(2, 1'b1, 1'b1, 1'b0);   // accepted read
        tick();
        c = cyc;
        drive_resp(4'b0100, {32'h0, 32'hA5A5_A5A5, 64'h0});
        idle(6);
        drive_resp(4'b0100, {32'h0, 32'h5A5A_5A5A, 64'h0});
        idle(8);
        n_checks++;
        if (q_data.size() != 1) begin n_err++; $display("FAIL single_count: got %0d pulses want 1", q_data.size()); end
        n_checks++;
        if (q_data.size() < 1 || q_data[0] !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL single_data: got %h want a5a5a5a5", (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        n_checks++;
        if (q_cyc.size() < 1 || q_cyc[0] != c + 4) begin
            n_err++; $display("FAIL single_latency: got cycle %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, c + 4);
        end
        $display("test_single_read: pulses=%0d", q_data.size());
    endtask

    task automatic test_fairness();
        int c;
        do_reset();
        for (int r = 0; r < 8; r++) issue(r % 4, 1'b1, 1'b1, 1'b0);
        idle(2);
        c = cyc;
        drive_resp(4'b1111, pack_k(1));
        drive_resp(4'b1111, pack_k(2));
        idle(14);
        n_checks++;
        if (q_data.size() != 8) begin n_err++; $display("FAIL fair_count: got %0d pulses want 8", q_data.size()); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= q_data.size()) begin
                n_err++; $display("FAIL fair_pulse[%0d]: got none want %h at cycle %0d", i, mk(i % 4, i / 4 + 1), c + 4 + i);
            end else if (q_data[i] !== mk(i % 4, i / 4 + 1) || q_cyc[i] != c + 4 + i) begin
                n_err++; $display("FAIL fair_pulse[%0d]: got %h at cycle %0d want %h at cycle %0d",
                                  i, q_data[i], q_cyc[i], mk(i % 4, i / 4 + 1), c + 4 + i);
            end
        end
        $display("test_fairness: pulses=%0d", q_data.size());
    endtask

    task automatic test_unsolicited();
        do_reset();
`ifdef RESP_ARB_ERR_EN
        n_checks++;
        if (err_unsol !== 1'b0) begin n_err++; $display("FAIL unsol_before: got %b want 0", err_unsol); end
`endif
        drive_resp(4'b0010, pack_k(3));
        idle(8);
        n_checks++;
        if (q_data.size() != 0) begin n_err++; $display("FAIL unsol_count: got %0d pulses want 0", q_data.size()); end
`ifdef RESP_ARB_ERR_EN
        n_checks++;
        if (err_unsol !== 1'b1 || err_ovf !== 1'b0) begin
            n_err++; $display("FAIL unsol_flags: got unsol=%b ovf=%b want 1 0", err_unsol, err_ovf);
        end
`endif
        $display("test_unsolicited: pulses=%0d", q_data.size());
    endtask

    task automatic test_simultaneous();
        int c;
        do_reset();
        issue(0, 1'b1, 1'b1, 1'b0);
        idle(3);
        c = cyc;
        drive_resp(4'b0001, pack_k(1));
        issue(0, 1'b1, 1'b1, 1'b0);   // increment lands with the push of entry 1
        idle(4);
        drive_resp(4'b0001, pack_k(2));
        idle(4);
        drive_resp(4'b0001, pack_k(3));   // no read left for this one
        idle(8);
        n_checks++;
        if (q_data.size() != 2) begin n_err++; $display("FAIL simul_count: got %0d pulses want 2", q_data.size()); end
        n_checks++;
        if (q_data.size() < 2 || q_data[0] !== mk(0, 1) || q_data[1] !== mk(0, 2) || q_cyc[0] != c + 4) begin
            n_err++; $display("FAIL simul_data: got %h,%h want %h,%h first at cycle %0d",
                              (q_data.size() > 0) ? q_data[0] : 32'hx, (q_data.size() > 1) ? q_data[1] : 32'hx,
                              mk(0, 1), mk(0, 2), c + 4);
        end
        $display("test_simultaneous: pulses=%0d", q_data.size());
    endtask

    // Six back-to-back responses on every channel outrun the rotation: channels 1..3
    // find their FIFO full with no pop at the sixth push and drop it; channel 0 keeps all.
    task automatic test_overflow();
        int c;
        do_reset();
        for (int r = 0; r < 24; r++) issue(r % 4, 1'b1, 1'b1, 1'b0);
        idle(2);
        c = cyc;
        for (int k = 1; k <= 6; k++) drive_resp(4'b1111, pack_k(k));
        idle(28);
        n_checks++;
        if (q_data.size() != 21) begin n_err++; $display("FAIL ovf_count: got %0d pulses want 21", q_data.size()); end
        for (int i = 0; i < 21; i++) begin
            n_checks++;
            if (i >= q_data.size()) begin
                n_err++; $display("FAIL ovf_pulse[%0d]: got none want %h", i, mk(i % 4, i / 4 + 1));
            end else if (q_data[i] !== mk(i % 4, i / 4 + 1) || q_cyc[i] != c + 4 + i) begin
                n_err++; $display("FAIL ovf_pulse[%0d]: got %h at cycle %0d want %h at cycle %0d",
                                  i, q_data[i], q_cyc[i], mk(i % 4, i / 4 + 1), c + 4 + i);
            end
        end
`ifdef RESP_ARB_ERR_EN
        n_checks++;
        if (err_ovf !== 1'b1 || err_unsol !== 1'b0) begin
            n_err++; $display("FAIL ovf_flags: got ovf=%b unsol=%b want 1 0", err_ovf, err_unsol);
        end
`endif
        $display("test_overflow: pulses=%0d", q_data.size());
    endtask

    task automatic test_reset_mid_burst();
        int c;
        do_reset();
        issue(0, 1'b1, 1'b1, 1'b0);      // leaves the last winner at channel 0
        idle(2);
        drive_resp(4'b0001, pack_k(7));
        idle(6);
        for (int r = 0; r < 3; r++) issue(1, 1'b1, 1'b1, 1'b0);
        idle(2);
        q_data.delete(); q_cyc.delete();
        for (int k = 1; k <= 3; k++) drive_resp(4'b0010, pack_k(k));
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        n_checks++;
        if (resp_out !== 1'b0) begin n_err++; $display("FAIL midrst_resp_out: got %b want 0", resp_out); end
        idle(8);
        n_checks++;
        if (q_data.size() != 0) begin n_err++; $display("FAIL midrst_flush: got %0d pulses want 0", q_data.size()); end
        issue(1, 1'b1, 1'b1, 1'b0);
        issue(0, 1'b1, 1'b1, 1'b0);
        idle(2);
        c = cyc;
        drive_resp(4'b0011, pack_k(5));
        idle(8);
        n_checks++;
        if (q_data.size() != 2 || q_data[0] !== mk(0, 5) || q_data[1] !== mk(1, 5) || q_cyc[0] != c + 4) begin
            n_err++; $display("FAIL midrst_recover: got %0d pulses first %h at cycle %0d want %h then %h from cycle %0d",
                              q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx,
                              (q_cyc.size() > 0) ? q_cyc[0] : -1, mk(0, 5), mk(1, 5), c + 4);
        end
        $display("test_reset_mid_burst: pulses=%0d", q_data.size());
    endtask

    // 256 reads against an 8-bit counter: it holds at 255, so the last response is unsolicited.
    task automatic test_counter_sat();
        do_reset();
        for (int r = 0; r < 256; r++) issue(0, 1'b1, 1'b1, 1'b0);
        idle(2);
        for (int k = 1; k <= 256; k++) begin
            rdata_in = '0;
            drive_resp(4'b0001, {96'h0, mk(0, k)});
        end
        idle(8);
        n_checks++;
        if (q_data.size() != 255) begin n_err++; $display("FAIL sat_count: got %0d pulses want 255", q_data.size()); end
        n_checks++;
        if (q_data.size() < 255 || q_data[0] !== mk(0, 1) || q_data[254] !== mk(0, 255)) begin
            n_err++; $display("FAIL sat_order: got first %h last %h want %h %h",
                              (q_data.size() > 0) ? q_data[0] : 32'hx,
                              (q_data.size() > 0) ? q_data[q_data.size()-1] : 32'hx, mk(0, 1), mk(0, 255));
        end
`ifdef RESP_ARB_ERR_EN
        n_checks++;
        if (err_ovf !== 1'b1 || err_unsol !== 1'b1) begin
            n_err++; $display("FAIL sat_flags: got ovf=%b unsol=%b want 1 1", err_ovf, err_unsol);
        end
`endif
        $display("test_counter_sat: pulses=%0d", q_data.size());
    endtask

    task automatic test_idle_zero();
        n_checks++;
        if (idle_bad != 0) begin n_err++; $display("FAIL idle_rdata_zero: got %0d nonzero idle cycles want 0", idle_bad); end
    endtask

    initial begin
        aresetn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_unsolicited();
        test_simultaneous();
        test_overflow();
        test_reset_mid_burst();
        test_counter_sat();
        test_idle_zero();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/resp_arbiter_n.md
RESP_ARBITER_N -- requirements
Module: resp_arbiter_n

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: response data width.
REQ-002 SHALL have parameter MASTER_NUM, default 4: number of master response channels, legal range 2..16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries per channel FIFO, power of two, at least 2.
REQ-004 SHALL have parameter RESP_DELAY, default 2: response alignment pipeline stages, at least 1.
REQ-005 SHALL have parameter OUTST_W, default 8: width of the per-channel outstanding-read counter.
REQ-006 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port aresetn, input, 1 bit: synchronous active-low reset.
REQ-008 SHALL have port req, input, 1 bit: slave-port request valid.
REQ-009 SHALL have port ack, input, 1 bit: request accepted.
REQ-010 SHALL have port cmd, input, 1 bit: 0 = read, 1 = write.
REQ-011 SHALL have port master_sel, input, $clog2(MASTER_NUM) bits: target channel of the request.
REQ-012 SHALL have port resp_in, input, MASTER_NUM bits: per-channel response strobe.
REQ-013 SHALL have port rdata_in, input, MASTER_NUM x DWIDTH bits: per-channel read data.
REQ-014 SHALL have port resp_out, output, 1 bit: returned-response strobe.
REQ-015 SHALL have port rdata_out, output, DWIDTH bits: returned data, 0 when resp_out is 0.
REQ-016 SHALL have port err_unsol, output, 1 bit (under RESP_ARB_ERR_EN only): sticky flag for an unsolicited response.
REQ-017 SHALL have port err_ovf, output, 1 bit (under RESP_ARB_ERR_EN only): sticky flag for FIFO or counter overflow.

Function
REQ-018 SHALL register rd_done = req & ack & !cmd, together with master_sel, one cycle after acceptance.
REQ-019 SHALL increment the selected channel's outstanding counter on rd_done.
- At the counter maximum: hold the value and raise overflow.
REQ-020 SHALL delay each channel's resp_in/rdata_in through RESP_DELAY register stages; the last stage is the push stage.
REQ-021 SHALL, at the push stage with a counter value above 0, push the data into that channel's FIFO and decrement the counter.
REQ-022 SHALL, at the push stage with a counter value of 0, discard the data, leave the FIFO unchanged and raise unsolicited.
REQ-023 SHALL leave a counter unchanged when it is incremented and decremented in the same cycle.
REQ-024 SHALL, when the target FIFO is full, discard the push, still decrement the counter and raise overflow.
REQ-025 SHALL, in each cycle with at least one non-empty FIFO, grant exactly one channel by round-robin.
- Search starts at last_grant+1 modulo MASTER_NUM.
- last_grant resets to MASTER_NUM-1, so channel 0 wins first.
REQ-026 SHALL pop the granted FIFO in the grant cycle and drive resp_out=1 with its head data on the next cycle.
- Latency: grant to output is 1 cycle.
- Throughput: 1 response per cycle, back-to-back allowed.
REQ-027 SHALL allow a push and a pop on the same FIFO in the same cycle, including when full, and lose no data.
REQ-028 SHALL make a pushed entry eligible for grant no earlier than the cycle after its push.
REQ-029 SHALL return data from each channel in push order; no order is guaranteed between channels.

Reset
REQ-030 SHALL, while aresetn=0 at a clock edge, clear:
- resp_out, rdata_out
- all counters, FIFO pointers and the alignment pipeline
- err_unsol, err_ovf
REQ-031 SHALL discard all in-flight data on a reset asserted mid-operation, with resp_out=0 on the cycle after the reset edge.

Configuration
REQ-032 SHALL, with RESP_ARB_ERR_EN defined, implement err_unsol and err_ovf, each set by its event and cleared only by reset.
REQ-033 SHALL, without RESP_ARB_ERR_EN, omit both error ports and their logic, with discard, saturation and arbitration behaviour unchanged.

Structure
REQ-034 SHALL take from shared package xbar_pkg:
- the read-command encoding constant
- the default OUTST_W
- a function returning log2 of the master count
REQ-035 SHALL place the rotating-priority grant logic in a sub-module rr_grant (request vector in, one-hot grant out, last_grant register inside), instantiated once.

Verification
REQ-036 SHALL cover single read: MASTER_NUM=4, read to master 2, resp_in[2] with 0xA5A5A5A5 two cycles later -> one resp_out pulse with 0xA5A5A5A5, RESP_DELAY+2 cycles after resp_in.
REQ-037 SHALL cover fairness: all 4 FIFOs holding 2 entries -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles, 8 pulses with no gaps.
REQ-038 SHALL cover unsolicited response: resp_in[1] with counter[1]=0 -> no resp_out, and err_unsol=1 (macro on) or absent (macro off).
REQ-039 SHALL cover overflow: FIFO_DEPTH=4, 5 reads and 5 responses to channel 3 with arbitration blocked by all FIFOs pre-filled -> first 4 entries returned in order, err_ovf=1.
REQ-040 SHALL cover simultaneous events: rd_done and push-stage response on channel 0 in the same cycle with counter=1 -> counter stays 1, data returned.
REQ-041 SHALL cover reset mid-burst: aresetn low for 1 cycle with 3 entries queued -> resp_out=0 afterwards, and the next read/response pair returns normally via channel 0 priority.
